reverb_fir_stream_arbiter: RTL and testbench
============================================

REVERB_FIR_STREAM_ARBITER -- requirements
Module: reverb_fir_stream_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning stream data width.
REQ-002 The block SHALL have port wrclock, input, 1, meaning the single clock for all logic.
REQ-003 The block SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-004 The block SHALL have ports ch0_valid/ch1_valid, input, 1 each, meaning the requester stream valid signals.
REQ-005 The block SHALL have ports ch0_data/ch1_data, input, DATA_W each, meaning the requester stream data.
REQ-006 The block SHALL have ports ch0_ready/ch1_ready, output, 1 each, meaning the requester stream ready signals.
REQ-007 The block SHALL have port fir_valid, output, 1, meaning FIR sink valid.
REQ-008 The block SHALL have port fir_data, output, DATA_W, meaning FIR sink data.
REQ-009 The block SHALL have port fir_channel, output, 1, meaning the index of the granted requester.
REQ-010 The block SHALL have port fir_ready, input, 1, meaning FIR sink ready.
REQ-011 The block SHALL have port ctrl_address, input, 2, meaning the control slave word address.
REQ-012 The block SHALL have ports ctrl_write/ctrl_read, input, 1 each, meaning control slave strobes.
REQ-013 The block SHALL have port ctrl_writedata, input, 32, meaning control slave write data.
REQ-014 The block SHALL have port ctrl_readdata, output, 32, meaning control slave registered read data.

Function
REQ-015 The block SHALL define a transfer as fir_valid & fir_ready on a rising wrclock edge.
REQ-016 The register map SHALL be: addr0 CTRL (bit0 enable, bits7:4 BLEN, burst = BLEN+1 beats), addr1 CNT0 (read-only), addr2 CNT1 (read-only), addr3 STATUS (bits1:0 state, bit2 last_grant).
REQ-017 CNT0/CNT1 SHALL increment by 1 per ch0/ch1 transfer, wrap from 0xFFFFFFFF to 0, and clear to 0 on any write to their own address; a clear coinciding with a transfer SHALL leave the counter at 0.
REQ-018 A read SHALL present data on ctrl_readdata one cycle after ctrl_read; unused bits SHALL read 0; writes to addr3 SHALL be ignored.
REQ-019 The FSM SHALL have states IDLE(0), GRANT0(1), GRANT1(2); encoding 3 is unreachable and SHALL recover to IDLE.
REQ-020 In IDLE with enable=1: both valid -> grant the channel != last_grant; one valid -> grant that channel; none -> stay. The grant SHALL take effect the next cycle.
REQ-021 On grant, the block SHALL latch burst length from BLEN and clear the beat counter; a BLEN change mid-burst SHALL NOT affect the current burst.
REQ-022 In GRANTx: fir_valid=chx_valid, fir_data=chx_data, fir_channel=x, chx_ready=fir_ready; the other ready SHALL be 0 (combinational, zero latency).
REQ-023 In IDLE: fir_valid=0, both readys=0, fir_channel=last_grant, fir_data=0.
REQ-024 The burst SHALL end on the transfer that completes the latched length, or on any cycle where chx_valid=0 while the other channel's valid=1 (starvation release).
REQ-025 At burst end: the block SHALL set last_grant=x; if enable and the other channel is valid, it SHALL go directly to the other GRANT (no bubble); else if enable and chx_valid, it SHALL start a new burst on x; else it SHALL go to IDLE.
REQ-026 A clear of enable mid-burst SHALL take effect only at burst end.
REQ-027 Simultaneous CTRL write and burst end SHALL use the newly written enable/BLEN for the decision.

Reset
REQ-028 Asserting reset_n low SHALL immediately force state=IDLE, last_grant=1, enable=0, BLEN=3, CNT0=CNT1=0, ctrl_readdata=0, and beat counter=0; fir_valid and both readys SHALL be 0 while reset is asserted, including mid-burst.

Verification
REQ-029 The bench SHALL cover: enable=1, BLEN=3, both channels continuously valid, fir_ready=1 -> fir_channel sequence 0,0,0,0,1,1,1,1,0... with no idle cycle between bursts.
REQ-030 The bench SHALL cover: ch0 only valid, BLEN=0 -> back-to-back single-beat bursts on ch0, CNT0 increments every cycle, CNT1=0.
REQ-031 The bench SHALL cover: in GRANT0, ch0_valid drops while ch1_valid=1 -> next cycle GRANT1, STATUS.bit2=0.
REQ-032 The bench SHALL cover: fir_ready toggling 1,0,1,0 during BLEN=1 -> the burst completes after exactly 2 transfers, with ch0_ready mirroring fir_ready.
REQ-033 The bench SHALL cover: enable cleared during beat 2 of 4 -> beats 3 and 4 still transfer, then IDLE with fir_valid=0.
REQ-034 The bench SHALL cover: reset_n pulsed low mid-burst -> fir_valid=0 asynchronously, CTRL reads 0x00000030, counters read 0.

Source files
------------

// File: rtl/reverb_fir_stream_arbiter.sv
// Two-channel burst arbiter feeding a single FIR sink stream, with a small
// control slave for enable/burst length, per-channel transfer counters and status.
module reverb_fir_stream_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              wrclock,
  input  logic              reset_n,
  input  logic              ch0_valid,
  input  logic [DATA_W-1:0] ch0_data,
  output logic              ch0_ready,
  input  logic              ch1_valid,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              ch1_ready,
  output logic              fir_valid,
  output logic [DATA_W-1:0] fir_data,
  output logic              fir_channel,
  input  logic              fir_ready,
  input  logic [1:0]        ctrl_address,
  input  logic              ctrl_write,
  input  logic              ctrl_read,
  input  logic [31:0]       ctrl_writedata,
  output logic [31:0]       ctrl_readdata
);

  // state  | meaning
  // IDLE   | no owner, waiting for a valid requester while enabled
  // GRANT0 | ch0 owns the sink for the current burst
  // GRANT1 | ch1 owns the sink for the current burst
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_q;
  logic [3:0]  len_q;
  logic [3:0]  beat_q;
  logic        en_q,  en_d;
  logic [3:0]  blen_q, blen_d;
  logic [31:0] cnt0_q, cnt1_q;
  logic [31:0] rdata_q;

  logic wr_ctrl, grant0, grant1, cur_valid, oth_valid, xfer, burst_end;
  logic unused_wdata;

  assign unused_wdata = ^{ctrl_writedata[31:8], ctrl_writedata[3:1]};

  // A CTRL write in the same cycle as a grant decision must steer that decision.
  assign wr_ctrl = ctrl_write && (ctrl_address == 2'd0);
  assign en_d    = wr_ctrl ? ctrl_writedata[0]   : en_q;
  assign blen_d  = wr_ctrl ? ctrl_writedata[7:4] : blen_q;

  assign grant0    = (state_q == GRANT0);
  assign grant1    = (state_q == GRANT1);
  assign cur_valid = grant1 ? ch1_valid : ch0_valid;
  assign oth_valid = grant1 ? ch0_valid : ch1_valid;
  assign xfer      = fir_valid && fir_ready;
  assign burst_end = (grant0 || grant1) &&
                     ((xfer && (beat_q == len_q)) || (!cur_valid && oth_valid));

  always_comb begin
    fir_valid   = 1'b0;
    fir_data    = '0;
    fir_channel = last_q;
    ch0_ready   = 1'b0;
    ch1_ready   = 1'b0;
    case (state_q)
      GRANT0: begin
        fir_valid   = ch0_valid;
        fir_data    = ch0_data;
        fir_channel = 1'b0;
        ch0_ready   = fir_ready;
      end
      GRANT1: begin
        fir_valid   = ch1_valid;
        fir_data    = ch1_data;
        fir_channel = 1'b1;
        ch1_ready   = fir_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_d && (ch0_valid || ch1_valid)) begin
            if (ch0_valid && ch1_valid) state_q <= last_q ? GRANT0 : GRANT1;
            else if (ch0_valid)         state_q <= GRANT0;
            else                        state_q <= GRANT1;
            len_q  <= blen_d;
            beat_q <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (burst_end) begin
            last_q <= grant1;
            if (en_d && oth_valid) begin
              state_q <= grant1 ? GRANT0 : GRANT1;
              len_q   <= blen_d;
              beat_q  <= '0;
            end else if (en_d && cur_valid) begin
              len_q  <= blen_d;
              beat_q <= '0;
            end else begin
              state_q <= IDLE;
              beat_q  <= '0;
            end
          end else if (xfer) begin
            beat_q <= beat_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      en_q    <= 1'b0;
      blen_q  <= 4'd3;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      rdata_q <= '0;
    end else begin
      en_q   <= en_d;
      blen_q <= blen_d;
      if (ctrl_write && (ctrl_address == 2'd1)) cnt0_q <= '0;
      else if (xfer && grant0)                  cnt0_q <= cnt0_q + 32'd1;
      if (ctrl_write && (ctrl_address == 2'd2)) cnt1_q <= '0;
      else if (xfer && grant1)                  cnt1_q <= cnt1_q + 32'd1;
      if (ctrl_read) begin
        case (ctrl_address)
          2'd0:    rdata_q <= {24'd0, blen_q, 3'd0, en_q};
          2'd1:    rdata_q <= cnt0_q;
          2'd2:    rdata_q <= cnt1_q;
          default: rdata_q <= {29'd0, last_q, state_q};
        endcase
      end
    end
  end

  assign ctrl_readdata = rdata_q;

endmodule

// File: tb/tb_reverb_fir_stream_arbiter.sv
// Directed and randomized bench for reverb_fir_stream_arbiter; a cycle-level
// owner/beats-remaining model predicts every output.
module tb_reverb_fir_stream_arbiter;
  localparam int DW = 32;

  logic          wrclock = 1'b0;
  logic          reset_n = 1'b1;
  logic          ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic [DW-1:0] ch0_data = '0, ch1_data = '0;
  logic          ch0_ready, ch1_ready;
  logic          fir_valid, fir_channel;
  logic [DW-1:0] fir_data;
  logic          fir_ready = 1'b0;
  logic [1:0]    ctrl_address = '0;
  logic          ctrl_write = 1'b0, ctrl_read = 1'b0;
  logic [31:0]   ctrl_writedata = '0;
  logic [31:0]   ctrl_readdata;

  reverb_fir_stream_arbiter #(.DATA_W(DW)) dut (
    .wrclock(wrclock), .reset_n(reset_n),
    .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
    .fir_valid(fir_valid), .fir_data(fir_data), .fir_channel(fir_channel),
    .fir_ready(fir_ready), .ctrl_address(ctrl_address), .ctrl_write(ctrl_write),
    .ctrl_read(ctrl_read), .ctrl_writedata(ctrl_writedata), .ctrl_readdata(ctrl_readdata)
  );

  always #5 wrclock = ~wrclock;

  int checks = 0;
  int passed = 0;

  // Reference model: owner -1 means nobody holds the sink.
  int          m_owner, m_last, m_rem;
  logic        m_en;
  logic [3:0]  m_blen;
  logic [31:0] m_cnt [2];
  logic [31:0] m_rd;
  bit          m_rd_pend;
  logic        o_valid, o_ch, o_r0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_rem = 0;
    m_en = 1'b0; m_blen = 4'd3;
    m_cnt[0] = '0; m_cnt[1] = '0;
    m_rd = '0; m_rd_pend = 1'b0;
  endtask

  task automatic check_outputs();
    logic ev, ec, er0, er1;
    logic [DW-1:0] ed;
    if (m_owner < 0) begin
      ev = 1'b0; ed = '0; ec = m_last[0]; er0 = 1'b0; er1 = 1'b0;
    end else begin
      ev  = (m_owner == 0) ? ch0_valid : ch1_valid;
      ed  = (m_owner == 0) ? ch0_data  : ch1_data;
      ec  = (m_owner == 1);
      er0 = (m_owner == 0) && fir_ready;
      er1 = (m_owner == 1) && fir_ready;
    end
    chk("fir_valid", 32'(fir_valid), 32'(ev));
    chk("fir_data", fir_data, ed);
    chk("fir_channel", 32'(fir_channel), 32'(ec));
    chk("ch0_ready", 32'(ch0_ready), 32'(er0));
    chk("ch1_ready", 32'(ch1_ready), 32'(er1));
    o_valid = fir_valid; o_ch = fir_channel; o_r0 = ch0_ready;
  endtask

  task automatic model_step();
    bit v [2];
    logic en_n;
    logic [3:0] blen_n;
    bit xfer, ended;
    int x;
    v[0] = ch0_valid; v[1] = ch1_valid;
    en_n = m_en; blen_n = m_blen;
    if (ctrl_write && ctrl_address == 2'd0) begin
      en_n = ctrl_writedata[0]; blen_n = ctrl_writedata[7:4];
    end
    m_rd_pend = ctrl_read;
    if (ctrl_read) begin
      case (ctrl_address)
        2'd0: m_rd = {24'd0, m_blen, 3'd0, m_en};
        2'd1: m_rd = m_cnt[0];
        2'd2: m_rd = m_cnt[1];
        default: m_rd = 32'(m_last * 4 + m_owner + 1);
      endcase
    end
    xfer = (m_owner >= 0) && v[m_owner] && fir_ready;
    if (xfer) m_cnt[m_owner] = m_cnt[m_owner] + 32'd1;
    if (ctrl_write && ctrl_address == 2'd1) m_cnt[0] = '0;
    if (ctrl_write && ctrl_address == 2'd2) m_cnt[1] = '0;
    if (m_owner < 0) begin
      if (en_n) begin
        if (v[0] && v[1]) m_owner = 1 - m_last;
        else if (v[0])    m_owner = 0;
        else if (v[1])    m_owner = 1;
        if (m_owner >= 0) m_rem = int'(blen_n) + 1;
      end
    end else begin
      x = m_owner; ended = 1'b0;
      if (xfer) begin
        m_rem--;
        if (m_rem == 0) ended = 1'b1;
      end
      if (!v[x] && v[1-x]) ended = 1'b1;
      if (ended) begin
        m_last = x;
        if (en_n && v[1-x]) begin
          m_owner = 1 - x; m_rem = int'(blen_n) + 1;
        end else if (en_n && v[x]) begin
          m_rem = int'(blen_n) + 1;
        end else begin
          m_owner = -1;
        end
      end
    end
    m_en = en_n; m_blen = blen_n;
  endtask

  // Entered and left at posedge+1; inputs set by the caller hold for one cycle.
  task automatic tick();
    ch0_data = $urandom; ch1_data = $urandom;
    #2;
    check_outputs();
    @(posedge wrclock);
    model_step();
    #1;
    if (m_rd_pend) chk("ctrl_readdata", ctrl_readdata, m_rd);
    ctrl_write = 1'b0; ctrl_read = 1'b0;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    ctrl_write = 1'b1; ctrl_address = a; ctrl_writedata = d;
    tick();
  endtask

  task automatic rd(logic [1:0] a);
    ctrl_read = 1'b1; ctrl_address = a;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_fir_valid", 32'(fir_valid), 32'd0);
    chk("rst_ch0_ready", 32'(ch0_ready), 32'd0);
    chk("rst_ch1_ready", 32'(ch1_ready), 32'd0);
    model_reset();
    ch0_valid = 1'b0; ch1_valid = 1'b0; fir_ready = 1'b0;
    ctrl_write = 1'b0; ctrl_read = 1'b0;
    @(posedge wrclock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int r;
    #1;
    do_reset();
    rd(2'd0); chk("ctrl_reset", ctrl_readdata, 32'h30);
    rd(2'd3); chk("status_reset", ctrl_readdata, 32'h4);

    // Alternating 4-beat bursts with both channels always valid.
    wr(2'd0, 32'h31);
    ch0_valid = 1'b1; ch1_valid = 1'b1; fir_ready = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("seq_valid", 32'(o_valid), 32'd1);
      chk("seq_ch", 32'(o_ch), 32'((i / 4) % 2));
    end
    tick();
    do_reset();
    rd(2'd0); chk("ctrl_after_rst", ctrl_readdata, 32'h30);
    rd(2'd1); chk("cnt0_after_rst", ctrl_readdata, 32'h0);
    rd(2'd2); chk("cnt1_after_rst", ctrl_readdata, 32'h0);

    // Single-beat bursts on ch0 only.
    wr(2'd0, 32'h01);
    ch0_valid = 1'b1; fir_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("blen0_ch", 32'(o_ch), 32'd0);
      chk("blen0_valid", 32'(o_valid), 32'd1);
    end
    rd(2'd1); chk("blen0_cnt0", ctrl_readdata, 32'd8);
    rd(2'd2); chk("blen0_cnt1", ctrl_readdata, 32'd0);

    // Starvation release from GRANT0 to GRANT1.
    do_reset();
    wr(2'd0, 32'h31);
    ch0_valid = 1'b1; fir_ready = 1'b1;
    tick();
    tick();
    ch0_valid = 1'b0; ch1_valid = 1'b1;
    tick();
    rd(2'd3);
    chk("starve_ch", 32'(o_ch), 32'd1);
    chk("starve_status", ctrl_readdata, 32'h2);

    // Stalling sink during a 2-beat burst.
    do_reset();
    wr(2'd0, 32'h11);
    ch0_valid = 1'b1; ch1_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      fir_ready = (i % 2 == 0);
      tick();
      chk("stall_ch", 32'(o_ch), (i == 3) ? 32'd1 : 32'd0);
      if (i < 3) chk("stall_ready", 32'(o_r0), 32'(fir_ready));
    end

    // Enable cleared during beat 2 of 4.
    do_reset();
    wr(2'd0, 32'h31);
    ch0_valid = 1'b1; fir_ready = 1'b1;
    tick();
    tick();
    wr(2'd0, 32'h30);
    tick(); chk("dis_beat3", 32'(o_valid), 32'd1);
    tick(); chk("dis_beat4", 32'(o_valid), 32'd1);
    tick(); chk("dis_idle", 32'(o_valid), 32'd0);

    // Randomized traffic and control accesses.
    do_reset();
    wr(2'd0, 32'h31);
    for (int n = 0; n < 700; n++) begin
      if (n == 350) begin
        do_reset();
        wr(2'd0, 32'h21);
      end
      ch0_valid = ($urandom_range(0, 3) != 0);
      ch1_valid = ($urandom_range(0, 3) != 0);
      fir_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      if (r == 0) begin
        d = $urandom;
        if ($urandom_range(0, 7) != 0) d[0] = 1'b1;
        wr(2'($urandom_range(0, 3)), d);
      end else if (r == 1 || r == 2) begin
        rd(2'($urandom_range(0, 3)));
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
